// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving io loader, euler unit and step-size unit shared access to one RAM.
// Optional hold-limit pre-emption is compiled in with `define RAM_ARB_PREEMPT_EN.
module ram_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [5:0]   req_wr_rd,
  input  logic [191:0] req_addr,
  input  logic [191:0] req_wdata,
  output logic [2:0]   grant,
  output logic [63:0]  address,
  output logic [63:0]  to_ram,
  output logic [1:0]   WR_RD,
  input  logic [63:0]  from_ram,
  output logic [63:0]  rdata,
  output logic [2:0]   rvalid,
  output logic         cmd_err
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("ram_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_ILLEG = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [63:0] address_q, address_d;
  logic [63:0] to_ram_q, to_ram_d;
  logic [1:0]  wr_rd_q, wr_rd_d;
  logic        cmd_err_q, cmd_err_d;
  logic        rd1_vld_q, rd1_vld_d;
  logic [1:0]  rd1_own_q, rd1_own_d;
  logic        rd2_vld_q;
  logic [1:0]  rd2_own_q;

`ifdef RAM_ARB_PREEMPT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  logic        issue;
  logic [1:0]  cmd_sel;
  logic [63:0] addr_sel;
  logic [63:0] wdata_sel;

  // First requester after 'last' in the order 0->1->2->0; caller guarantees r != 0.
  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] pick;
    int         t;
    pick = last;
    for (int k = 3; k >= 1; k--) begin
      t = (int'(last) + k) % 3;
      if (r[t]) pick = 2'(t);
    end
    return pick;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign grant = (state_q == OWNED) ? onehot(owner_q) : 3'b000;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
`ifdef RAM_ARB_PREEMPT_EN
    hold_d       = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWNED;
          owner_d = rr_next(last_owner_q, req);
`ifdef RAM_ARB_PREEMPT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          if (|req) begin
            owner_d = rr_next(owner_q, req);
          end else begin
            state_d = IDLE;
          end
`ifdef RAM_ARB_PREEMPT_EN
          hold_d = 8'd0;
        end else if (hold_q >= HOLD_LAST && |(req & ~grant)) begin
          owner_d = rr_next(owner_q, req & ~grant);
          hold_d  = 8'd0;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OWNED) last_owner_d = owner_d;
  end

  always_comb begin
    cmd_sel   = req_wr_rd[1:0];
    addr_sel  = req_addr[63:0];
    wdata_sel = req_wdata[63:0];
    case (owner_q)
      2'd1: begin
        cmd_sel   = req_wr_rd[3:2];
        addr_sel  = req_addr[127:64];
        wdata_sel = req_wdata[127:64];
      end
      2'd2: begin
        cmd_sel   = req_wr_rd[5:4];
        addr_sel  = req_addr[191:128];
        wdata_sel = req_wdata[191:128];
      end
      default: ;
    endcase
  end

  // Only the current owner with its request still high reaches the RAM.
  assign issue = (state_q == OWNED) && req[owner_q];

  always_comb begin
    address_d = address_q;
    to_ram_d  = to_ram_q;
    wr_rd_d   = CMD_NONE;
    cmd_err_d = cmd_err_q;
    rd1_vld_d = 1'b0;
    rd1_own_d = owner_q;
    if (issue) begin
      address_d = addr_sel;
      to_ram_d  = wdata_sel;
      if (cmd_sel == CMD_ILLEG) begin
        cmd_err_d = 1'b1;
      end else begin
        wr_rd_d = cmd_sel;
      end
      rd1_vld_d = (cmd_sel == CMD_READ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      address_q    <= '0;
      to_ram_q     <= '0;
      wr_rd_q      <= CMD_NONE;
      cmd_err_q    <= 1'b0;
      rd1_vld_q    <= 1'b0;
      rd1_own_q    <= 2'd0;
      rd2_vld_q    <= 1'b0;
      rd2_own_q    <= 2'd0;
`ifdef RAM_ARB_PREEMPT_EN
      hold_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      address_q    <= address_d;
      to_ram_q     <= to_ram_d;
      wr_rd_q      <= wr_rd_d;
      cmd_err_q    <= cmd_err_d;
      rd1_vld_q    <= rd1_vld_d;
      rd1_own_q    <= rd1_own_d;
      rd2_vld_q    <= rd1_vld_q;
      rd2_own_q    <= rd1_own_q;
`ifdef RAM_ARB_PREEMPT_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign address = address_q;
  assign to_ram  = to_ram_q;
  assign WR_RD   = wr_rd_q;
  assign cmd_err = cmd_err_q;
  // The read owner travels with the command so data returns to it even after a handoff.
  assign rvalid  = rd2_vld_q ? onehot(rd2_own_q) : 3'b000;
  assign rdata   = rst ? 64'd0 : from_ram;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, writes, round-robin handoff, read return,
// illegal command, hold behaviour and reset during a read.
module tb_ram_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [5:0]   req_wr_rd;
  logic [191:0] req_addr;
  logic [191:0] req_wdata;
  logic [2:0]   grant;
  logic [63:0]  address;
  logic [63:0]  to_ram;
  logic [1:0]   WR_RD;
  logic [63:0]  from_ram;
  logic [63:0]  rdata;
  logic [2:0]   rvalid;
  logic         cmd_err;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr_rd(req_wr_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
    .address(address), .to_ram(to_ram), .WR_RD(WR_RD),
    .from_ram(from_ram), .rdata(rdata), .rvalid(rvalid), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [1:0] c, input logic [63:0] a,
                         input logic [63:0] d);
    req_wr_rd[2*i +: 2] = c;
    req_addr[64*i +: 64] = a;
    req_wdata[64*i +: 64] = d;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_wr_rd = '0;
    req_addr = '0;
    req_wdata = '0;
    from_ram = 64'h99;
    step();
    step();
    check("rst_grant",   64'(grant),   64'h0);
    check("rst_wr_rd",   64'(WR_RD),   64'h0);
    check("rst_address", address,      64'h0);
    check("rst_to_ram",  to_ram,       64'h0);
    check("rst_rvalid",  64'(rvalid),  64'h0);
    check("rst_rdata",   rdata,        64'h0);
    check("rst_cmd_err", 64'(cmd_err), 64'h0);

    // Write from io loader
    rst = 1'b0;
    req = 3'b001;
    set_cmd(0, 2'b10, 64'h4, 64'hAB);
    step();
    check("wr_grant",    64'(grant), 64'h1);
    check("wr_cmd_lat",  64'(WR_RD), 64'h0);
    step();
    check("wr_wr_rd",    64'(WR_RD), 64'h2);
    check("wr_address",  address,    64'h4);
    check("wr_to_ram",   to_ram,     64'hAB);
    set_cmd(0, 2'b00, 64'h4, 64'hAB);
    step();
    check("wr_idle_cmd", 64'(WR_RD), 64'h0);
    check("wr_addr_hold", address,   64'h4);

    // Round robin 0 -> 1 -> 2 -> 0, three cycles each, no idle gap
    req = 3'b110;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_euler", 64'(grant), 64'h2);
    end
    req = 3'b101;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_step", 64'(grant), 64'h4);
    end
    req = 3'b011;
    step();
    check("rr_io", 64'(grant), 64'h1);

    // Euler read, then handoff to step unit while the data is in flight
    req = 3'b010;
    set_cmd(1, 2'b01, 64'h10, 64'h0);
    step();
    check("rd_grant",  64'(grant), 64'h2);
    req = 3'b110;
    step();
    check("rd_wr_rd",   64'(WR_RD),  64'h1);
    check("rd_address", address,     64'h10);
    check("rd_rv_early", 64'(rvalid), 64'h0);
    req = 3'b100;
    set_cmd(1, 2'b00, 64'h10, 64'h0);
    step();
    from_ram = 64'h55;
    #1;
    check("rd_rvalid", 64'(rvalid), 64'h2);
    check("rd_rdata",  rdata,       64'h55);
    check("rd_handoff", 64'(grant), 64'h4);
    step();
    check("rd_rv_once", 64'(rvalid), 64'h0);

    // Illegal command from owner; non-owner command ignored
    set_cmd(2, 2'b11, 64'h30, 64'h0);
    step();
    check("ill_wr_rd",   64'(WR_RD),   64'h0);
    check("ill_cmd_err", 64'(cmd_err), 64'h1);
    check("ill_address", address,      64'h30);
    set_cmd(2, 2'b00, 64'h30, 64'h0);
    req = 3'b110;
    set_cmd(1, 2'b10, 64'h77, 64'h11);
    step();
    check("nonown_wr_rd", 64'(WR_RD), 64'h0);
    check("nonown_addr",  address,    64'h30);
    check("nonown_grant", 64'(grant), 64'h4);
    req = 3'b100;
    set_cmd(1, 2'b00, 64'h0, 64'h0);
    step();
    check("drop_nonown", 64'(grant),   64'h4);
    check("err_sticky",  64'(cmd_err), 64'h1);

    // Hold behaviour: io holds while euler waits
    req = 3'b001;
    step();
    check("hold_io_first", 64'(grant), 64'h1);
    req = 3'b011;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_io", 64'(grant), 64'h1);
    end
`ifdef RAM_ARB_PREEMPT_EN
    step();
    check("preempt_to_euler", 64'(grant), 64'h2);
    req = 3'b001;
    step();
    check("preempt_reserve_io", 64'(grant), 64'h1);
`else
    for (int k = 0; k < 12; k++) begin
      step();
      check("no_preempt_io", 64'(grant), 64'h1);
    end
    req = 3'b001;
`endif

    // Reset one cycle after a granted read
    set_cmd(0, 2'b01, 64'h8, 64'h0);
    step();
    check("rr_rd_wr_rd", 64'(WR_RD), 64'h1);
    check("rr_rd_addr",  address,    64'h8);
    rst = 1'b1;
    #1;
    check("mid_rst_grant",   64'(grant),   64'h0);
    check("mid_rst_wr_rd",   64'(WR_RD),   64'h0);
    check("mid_rst_address", address,      64'h0);
    check("mid_rst_rvalid",  64'(rvalid),  64'h0);
    check("mid_rst_rdata",   rdata,        64'h0);
    check("mid_rst_cmd_err", 64'(cmd_err), 64'h0);
    req = 3'b000;
    set_cmd(0, 2'b00, 64'h0, 64'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_rvalid", 64'(rvalid), 64'h0);
      check("post_rst_grant",  64'(grant),  64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive grant cycles when pre-emption is compiled in (range 2..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 req  in  3  SHALL carry the per-requester bus request; bit 0 = io loader, bit 1 = euler unit, bit 2 = step-size unit.
REQ-005 req_wr_rd  in  6  SHALL carry the per-requester 2-bit command, requester i at [2i+1:2i]: 10 = write, 01 = read, 00 = none, 11 = illegal.
REQ-006 req_addr  in  192  SHALL carry the per-requester 64-bit address, requester i at [64i+63:64i].
REQ-007 req_wdata  in  192  SHALL carry the per-requester 64-bit write data, packed the same way as req_addr.
REQ-008 grant  out  3  SHALL be the one-hot-or-zero grant vector.
REQ-009 address, to_ram  out  64 each  SHALL be the registered RAM address and write data.
REQ-010 WR_RD  out  2  SHALL be the registered RAM command.
REQ-011 from_ram  in  64  SHALL be the RAM read data, valid one cycle after a read command is presented on WR_RD.
REQ-012 rdata  out  64  SHALL broadcast from_ram to all requesters; rvalid  out  3 SHALL flag the owner of rdata.
REQ-013 cmd_err  out  1  SHALL be a sticky illegal-command flag.

Function
REQ-014 FSM states SHALL be IDLE and OWNED.
- IDLE: grant = 000.
- OWNED: exactly one grant bit is set.
REQ-015 In IDLE with req != 0, the arbiter SHALL enter OWNED at the next edge and grant the first set bit after last_owner, in round-robin order 0->1->2->0; last_owner SHALL reset to 2, so requester 0 has first priority.
REQ-016 In OWNED, when req[owner] is low at an edge, the arbiter SHALL hand over at that edge to the next round-robin requester with req high, or enter IDLE if none; zero-gap handoff.
REQ-017 When a requester is granted, last_owner SHALL update to that requester.
REQ-018 Each cycle with grant[i] & req[i]:
- address, to_ram and WR_RD SHALL register requester i's fields at the next edge (command latency 1 cycle).
- Otherwise WR_RD SHALL register 00; address and to_ram SHALL hold their values.
REQ-019 A command of 11 from the owner SHALL be forwarded as 00 and SHALL set cmd_err, which stays set until reset.
REQ-020 rvalid[i] SHALL assert for exactly one cycle, two cycles after the owner i presented a read (01) with grant[i] high; rdata SHALL equal from_ram in that cycle.
REQ-021 A read in flight SHALL complete to its original owner even if the grant changes before the data returns (2-deep owner pipeline).
REQ-022 Requests and commands from non-owners SHALL be ignored; the requester holds its command until granted.
REQ-023 A 1->0 transition on req while not granted SHALL have no effect.

Reset
REQ-024 While rst is high:
- state = IDLE; grant = 000; WR_RD = 00; address = 0; to_ram = 0.
- rvalid = 000; rdata = 0; cmd_err = 0; last_owner = 2; hold counter = 0; read pipeline cleared.
REQ-025 A reset asserted mid-read SHALL discard the pending rvalid; no rvalid SHALL appear after reset deassertion until a new read is granted.

Configuration
REQ-026 With RAM_ARB_PREEMPT_EN defined:
- A hold counter SHALL count OWNED cycles of the current owner.
- When the count reaches MAX_HOLD and any other req bit is high, the grant SHALL move at that edge to the next round-robin requester, and the counter SHALL clear.
- The pre-empted requester retains its request and is re-served in round-robin order.
REQ-027 Without RAM_ARB_PREEMPT_EN, no counter SHALL exist, and the owner SHALL keep the grant until it drops req.

Verification
REQ-028 Reset, then req=001 with a write (cmd 10, addr 0x4, data 0xAB) -> grant=001 after 1 edge; WR_RD=10, address=4, to_ram=0xAB one edge later.
REQ-029 req=111 held; each owner drops req after 3 cycles -> grant sequence 001, 010, 100, 001 with no IDLE gap.
REQ-030 Euler issues a read at addr 0x10 (from_ram=0x55 returned), then drops req the next cycle while step requests -> rvalid=010 with rdata=0x55 two cycles after the read; grant=100.
REQ-031 Owner drives cmd 11 -> WR_RD=00; cmd_err=1 and stays 1 until rst.
REQ-032 With RAM_ARB_PREEMPT_EN and MAX_HOLD=4: io holds req while euler waits -> grant moves to 010 after 4 OWNED cycles. Without the macro, grant stays 001 indefinitely.
REQ-033 rst asserted one cycle after a granted read -> all outputs zero immediately; no rvalid after release.
